// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch port (i_*) and the load/store port (d_*). D has priority,
// with a streak guard so a held fetch cannot starve. One access at a time:
// grant in IDLE, handshake in MEM, one-cycle completion pulse in RESP.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIME_LIMIT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            grant_d;
    logic            grant_i;
    logic            mem_done;
    logic            timed_out;

    logic            owner_d;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic            err_q;
    logic [DW-1:0]   i_rdata_q;
    logic [DW-1:0]   d_rdata_q;
    logic [SW-1:0]   streak;
    logic [TW-1:0]   tcount;

    // Arbitration in IDLE, ack/timeout detection in MEM, single RESP cycle.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        mem_done   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && streak == STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = MEM;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = MEM;
                end
            end
            MEM: begin
                // The ack wins over an expiry landing in the same cycle.
                if (mem_ack) begin
                    mem_done   = 1'b1;
                    state_next = RESP;
                end else if (tcount == TIME_LIMIT) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning request so requesters are only sampled in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_d <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant_d) begin
            owner_d <= 1'b1;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            be_q    <= d_we ? d_be : '1;
        end else if (grant_i) begin
            owner_d <= 1'b0;
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
        end
    end

    // Count D grants that overtook a waiting fetch; saturates, cleared otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!i_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

    // Count elapsed MEM cycles; expiry after TIMEOUT+1 cycles of mem_req.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcount <= '0;
        end else if (state == MEM && state_next == MEM) begin
            tcount <= tcount + 1'b1;
        end else begin
            tcount <= '0;
        end
    end

    // Capture the owner's read data and error flag on leaving MEM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (mem_done || timed_out) begin
            err_q <= timed_out;
            if (owner_d) begin
                d_rdata_q <= mem_done ? mem_rdata : '0;
            end else begin
                i_rdata_q <= mem_done ? mem_rdata : '0;
            end
        end
    end

    assign mem_req   = (state == MEM);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign i_ack   = (state == RESP) && !owner_d;
    assign d_ack   = (state == RESP) && owner_d;
    assign err     = (state == RESP) && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, self-checking bench for mem_arbiter. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_ack;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_STREAK(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd,
                                 input logic [3:0] db);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        d_be    = db;
    endtask

    // Called in the first MEM cycle; returns in the RESP cycle.
    task automatic serveMem(input int waitCycles, input logic [31:0] data);
        for (int n = 0; n < waitCycles; n++) nextCycle();
        mem_ack   = 1'b1;
        mem_rdata = data;
        nextCycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        string seq;
        logic  is_i;

        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        nextCycle();

        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_i_ack",   32'(i_ack),   32'h0);
        checkOutput("rst_d_ack",   32'(d_ack),   32'h0);
        checkOutput("rst_err",     32'(err),     32'h0);
        checkOutput("rst_mem_addr", mem_addr,    32'h0);
        checkOutput("rst_mem_be",  32'(mem_be),  32'h0);
        checkOutput("rst_i_rdata", i_rdata,      32'h0);
        reset = 1'b1;
        nextCycle();

        // Fetch only, memory acks three cycles after mem_req rises.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("f_mem_req",  32'(mem_req), 32'h1);
        checkOutput("f_mem_addr", mem_addr,     32'h100);
        checkOutput("f_mem_we",   32'(mem_we),  32'h0);
        checkOutput("f_mem_be",   32'(mem_be),  32'hF);
        serveMem(3, 32'h00500093);
        checkOutput("f_i_ack",   32'(i_ack),   32'h1);
        checkOutput("f_i_rdata", i_rdata,      32'h00500093);
        checkOutput("f_err",     32'(err),     32'h0);
        checkOutput("f_d_ack",   32'(d_ack),   32'h0);
        checkOutput("f_resp_mem_req", 32'(mem_req), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("f_i_ack_pulse", 32'(i_ack), 32'h0);

        // Store with partial byte enables.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3);
        nextCycle();
        checkOutput("s_mem_we",    32'(mem_we), 32'h1);
        checkOutput("s_mem_be",    32'(mem_be), 32'h3);
        checkOutput("s_mem_wdata", mem_wdata,   32'hDEADBEEF);
        checkOutput("s_mem_addr",  mem_addr,    32'h2004);
        serveMem(1, 32'h0);
        checkOutput("s_d_ack", 32'(d_ack), 32'h1);
        checkOutput("s_i_ack", 32'(i_ack), 32'h0);
        checkOutput("s_err",   32'(err),   32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("s_d_ack_pulse", 32'(d_ack), 32'h0);

        // Simultaneous requests straight out of reset: D first, then I.
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 4'h5);
        nextCycle();
        checkOutput("sim_d_addr", mem_addr,    32'h300);
        checkOutput("sim_d_we",   32'(mem_we), 32'h0);
        checkOutput("sim_d_be",   32'(mem_be), 32'hF);
        serveMem(0, 32'h11111111);
        checkOutput("sim_d_ack",   32'(d_ack), 32'h1);
        checkOutput("sim_d_rdata", d_rdata,    32'h11111111);
        checkOutput("sim_i_wait",  32'(i_ack), 32'h0);
        d_req = 1'b0;
        nextCycle();
        checkOutput("sim_idle_gap", 32'(mem_req), 32'h0);
        nextCycle();
        checkOutput("sim_i_addr", mem_addr,     32'h200);
        checkOutput("sim_i_req",  32'(mem_req), 32'h1);
        serveMem(0, 32'h22222222);
        checkOutput("sim_i_ack",   32'(i_ack), 32'h1);
        checkOutput("sim_i_rdata", i_rdata,    32'h22222222);
        checkOutput("sim_d_hold",  d_rdata,    32'h11111111);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();

        // Starvation guard: both held, expect D,D,D,D,I repeating.
        seq = "DDDDIDDDDI";
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        for (int g = 0; g < 10; g++) begin
            is_i = (seq[g] == "I");
            nextCycle();
            checkOutput($sformatf("stv_addr%0d", g), mem_addr, is_i ? 32'h400 : 32'h500);
            serveMem(0, 32'h10000000 + 32'(g));
            checkOutput($sformatf("stv_iack%0d", g), 32'(i_ack), is_i ? 32'h1 : 32'h0);
            checkOutput($sformatf("stv_dack%0d", g), 32'(d_ack), is_i ? 32'h0 : 32'h1);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();

        // Timeout: the memory never answers a load.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        nextCycle();
        checkOutput("to_mem_req_rise", 32'(mem_req), 32'h1);
        for (int n = 1; n <= 64; n++) nextCycle();
        checkOutput("to_still_waiting", 32'(mem_req), 32'h1);
        checkOutput("to_no_early_ack",  32'(d_ack),   32'h0);
        nextCycle();
        checkOutput("to_d_ack",   32'(d_ack),   32'h1);
        checkOutput("to_err",     32'(err),     32'h1);
        checkOutput("to_d_rdata", d_rdata,      32'h0);
        checkOutput("to_mem_req", 32'(mem_req), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("to_err_clear", 32'(err), 32'h0);

        // Ack landing exactly on the timeout cycle wins.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        nextCycle();
        serveMem(64, 32'hCAFEF00D);
        checkOutput("tob_d_ack",   32'(d_ack), 32'h1);
        checkOutput("tob_err",     32'(err),   32'h0);
        checkOutput("tob_d_rdata", d_rdata,    32'hCAFEF00D);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();

        // Reset pulse while a store is in MEM.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h800, 32'h12345678, 4'hC);
        nextCycle();
        checkOutput("rm_mem_req", 32'(mem_req), 32'h1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("rm_mem_req_drop", 32'(mem_req), 32'h0);
        checkOutput("rm_mem_we",    32'(mem_we), 32'h0);
        checkOutput("rm_mem_addr",  mem_addr,    32'h0);
        checkOutput("rm_mem_wdata", mem_wdata,   32'h0);
        checkOutput("rm_mem_be",    32'(mem_be), 32'h0);
        checkOutput("rm_d_ack",     32'(d_ack),  32'h0);
        checkOutput("rm_i_ack",     32'(i_ack),  32'h0);
        checkOutput("rm_err",       32'(err),    32'h0);
        checkOutput("rm_d_rdata",   d_rdata,     32'h0);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h00000BAD;
        nextCycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("rm_late_ack_d", 32'(d_ack),   32'h0);
        checkOutput("rm_late_ack_q", 32'(mem_req), 32'h0);
        applyStimulus(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("rm_new_addr", mem_addr,     32'h900);
        checkOutput("rm_new_req",  32'(mem_req), 32'h1);
        serveMem(2, 32'h0A0B0C0D);
        checkOutput("rm_new_iack",  32'(i_ack), 32'h1);
        checkOutput("rm_new_rdata", i_rdata,    32'h0A0B0C0D);
        checkOutput("rm_new_err",   32'(err),   32'h0);
        checkOutput("rm_new_dack",  32'(d_ack), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nextCycle();
        checkOutput("rm_new_pulse", 32'(i_ack), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
